// File: rtl/dma_copy.sv
// dma_copy: word-granular memory-to-memory copy engine on a req/gnt/rvalid host port.
// Optional DMA_FILL_EN: CTRL bit2 at start selects fill mode (SRC value as pattern).
module dma_copy #(
  parameter int unsigned LenWidth = 16
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        dev_req_i,
  input  logic        dev_we_i,
  input  logic [3:0]  dev_be_i,
  input  logic [31:0] dev_addr_i,
  input  logic [31:0] dev_wdata_i,
  output logic        dev_rvalid_o,
  output logic [31:0] dev_rdata_o,
  output logic        dev_err_o,
  output logic        host_req_o,
  input  logic        host_gnt_i,
  output logic [31:0] host_addr_o,
  output logic        host_we_o,
  output logic [3:0]  host_be_o,
  output logic [31:0] host_wdata_o,
  input  logic        host_rvalid_i,
  input  logic [31:0] host_rdata_i,
  input  logic        host_err_i,
  output logic        irq_o
);

  typedef enum logic [2:0] {
    IDLE, RD_REQ, RD_WAIT, WR_REQ, WR_WAIT
  } state_e;

  state_e              state_q;
  logic [31:0]         src_q, dst_q;
  logic [31:0]         src_ptr_q, dst_ptr_q;
  logic [31:0]         buf_q, addr_q, rdata_q;
  logic [LenWidth-1:0] len_q;
  logic                done_q, err_q, abort_q;
  logic                req_q, we_q, rvalid_q;
  logic                fill_q;

  logic        wr_en, busy, ctrl_wr;
  logic        start, irq_clr, abort_wr, abort_now;
  logic        rsp_ok, rsp_err, last_word;
  logic [1:0]  reg_sel;
  logic [31:0] rd_mux;
  logic        unused_addr;

  assign reg_sel   = dev_addr_i[3:2];
  assign wr_en     = dev_req_i & dev_we_i
                   & (dev_be_i == 4'hF);
  assign busy      = (state_q != IDLE);
  assign ctrl_wr   = wr_en & (reg_sel == 2'd3);
  assign start     = ctrl_wr & dev_wdata_i[0];
  assign irq_clr   = ctrl_wr & dev_wdata_i[1];
  assign abort_wr  = ctrl_wr & dev_wdata_i[3];
  assign abort_now = abort_q | abort_wr;
  assign rsp_ok    = host_rvalid_i & ~host_err_i;
  assign rsp_err   = host_rvalid_i & host_err_i;
  assign last_word = (len_q == LenWidth'(1));

  assign unused_addr = ^{dev_addr_i[31:4],
                         dev_addr_i[1:0]};

`ifndef DMA_FILL_EN
  assign fill_q = 1'b0;
`endif

  always_comb begin
    rd_mux = '0;
    unique case (reg_sel)
      2'd0:    rd_mux = {src_q[31:2], 2'b00};
      2'd1:    rd_mux = {dst_q[31:2], 2'b00};
      2'd2:    rd_mux = 32'(len_q);
      default: rd_mux = {27'd0, fill_q, 1'b0,
                         err_q, done_q, busy};
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rvalid_q <= 1'b0;
      rdata_q  <= '0;
    end else begin
      rvalid_q <= dev_req_i;
      rdata_q  <= (dev_req_i & ~dev_we_i)
                  ? rd_mux : '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= IDLE;
      src_q     <= '0;
      dst_q     <= '0;
      len_q     <= '0;
      src_ptr_q <= '0;
      dst_ptr_q <= '0;
      buf_q     <= '0;
      addr_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
      abort_q   <= 1'b0;
      req_q     <= 1'b0;
      we_q      <= 1'b0;
`ifdef DMA_FILL_EN
      fill_q    <= 1'b0;
`endif
    end else begin
      if (wr_en && !busy) begin
        unique case (reg_sel)
          2'd0:    src_q <= dev_wdata_i;
          2'd1:    dst_q <= dev_wdata_i;
          2'd2:    len_q <= dev_wdata_i[LenWidth-1:0];
          default: ;
        endcase
      end
      if (irq_clr) begin
        done_q <= 1'b0;
        err_q  <= 1'b0;
      end
      if (abort_wr && busy) abort_q <= 1'b1;

      unique case (state_q)
        IDLE: begin
          if (start) begin
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            abort_q <= 1'b0;
            if (len_q == '0) begin
              done_q <= 1'b1;
            end else begin
              src_ptr_q <= {src_q[31:2], 2'b00};
              dst_ptr_q <= {dst_q[31:2], 2'b00};
              req_q     <= 1'b1;
              state_q   <= RD_REQ;
              we_q      <= 1'b0;
              addr_q    <= {src_q[31:2], 2'b00};
`ifdef DMA_FILL_EN
              fill_q <= dev_wdata_i[2];
              if (dev_wdata_i[2]) begin
                state_q <= WR_REQ;
                we_q    <= 1'b1;
                addr_q  <= {dst_q[31:2], 2'b00};
                buf_q   <= src_q;
              end
`endif
            end
          end
        end
        RD_REQ: begin
          if (host_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (rsp_err) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            abort_q <= 1'b0;
            state_q <= IDLE;
          end else if (rsp_ok) begin
            buf_q <= host_rdata_i;
            if (abort_now) begin
              done_q  <= 1'b1;
              abort_q <= 1'b0;
              state_q <= IDLE;
            end else begin
              req_q   <= 1'b1;
              we_q    <= 1'b1;
              addr_q  <= dst_ptr_q;
              state_q <= WR_REQ;
            end
          end
        end
        WR_REQ: begin
          if (host_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= WR_WAIT;
          end
        end
        WR_WAIT: begin
          if (rsp_err) begin
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            abort_q <= 1'b0;
            we_q    <= 1'b0;
            state_q <= IDLE;
          end else if (rsp_ok) begin
            src_ptr_q <= src_ptr_q + 32'd4;
            dst_ptr_q <= dst_ptr_q + 32'd4;
            len_q     <= len_q - LenWidth'(1);
            if (last_word || abort_now) begin
              done_q  <= 1'b1;
              abort_q <= 1'b0;
              we_q    <= 1'b0;
              state_q <= IDLE;
            end else if (fill_q) begin
              req_q   <= 1'b1;
              addr_q  <= dst_ptr_q + 32'd4;
              state_q <= WR_REQ;
            end else begin
              req_q   <= 1'b1;
              we_q    <= 1'b0;
              addr_q  <= src_ptr_q + 32'd4;
              state_q <= RD_REQ;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dev_rvalid_o = rvalid_q;
  assign dev_rdata_o  = rdata_q;
  assign dev_err_o    = 1'b0;
  assign host_req_o   = req_q;
  assign host_we_o    = we_q;
  assign host_addr_o  = addr_q;
  assign host_be_o    = 4'hF;
  assign host_wdata_o = buf_q;
  assign irq_o        = done_q | err_q;

endmodule

// File: tb/tb_dma_copy.sv
// tb_dma_copy: randomized bench for dma_copy with a bus memory and a transfer-level model.
// Define DMA_FILL_EN to also exercise fill mode.
module tb_dma_copy;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        dev_req_i = 1'b0;
  logic        dev_we_i = 1'b0;
  logic [3:0]  dev_be_i = 4'h0;
  logic [31:0] dev_addr_i = '0;
  logic [31:0] dev_wdata_i = '0;
  logic        dev_rvalid_o;
  logic [31:0] dev_rdata_o;
  logic        dev_err_o;
  logic        host_req_o;
  logic        host_gnt_i = 1'b0;
  logic [31:0] host_addr_o;
  logic        host_we_o;
  logic [3:0]  host_be_o;
  logic [31:0] host_wdata_o;
  logic        host_rvalid_i = 1'b0;
  logic [31:0] host_rdata_i = '0;
  logic        host_err_i = 1'b0;
  logic        irq_o;

  always #5 clk = ~clk;

  dma_copy dut (
    .clk_i        (clk),
    .rst_ni       (rst_n),
    .dev_req_i    (dev_req_i),
    .dev_we_i     (dev_we_i),
    .dev_be_i     (dev_be_i),
    .dev_addr_i   (dev_addr_i),
    .dev_wdata_i  (dev_wdata_i),
    .dev_rvalid_o (dev_rvalid_o),
    .dev_rdata_o  (dev_rdata_o),
    .dev_err_o    (dev_err_o),
    .host_req_o   (host_req_o),
    .host_gnt_i   (host_gnt_i),
    .host_addr_o  (host_addr_o),
    .host_we_o    (host_we_o),
    .host_be_o    (host_be_o),
    .host_wdata_o (host_wdata_o),
    .host_rvalid_i(host_rvalid_i),
    .host_rdata_i (host_rdata_i),
    .host_err_i   (host_err_i),
    .irq_o        (irq_o)
  );

  int unsigned n_checks = 0;
  int unsigned n_errs = 0;

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h",
               tag, got, exp);
    end
  endtask

  typedef struct packed {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } txn_t;

  logic [31:0] mem [logic [31:0]];
  txn_t log_q[$];
  txn_t exp_q[$];

  function automatic logic [31:0] mrd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 32'h0;
  endfunction

  function automatic txn_t mk(input logic w,
                              input logic [31:0] a,
                              input logic [31:0] d);
    txn_t t;
    t.we = w;
    t.addr = a;
    t.data = d;
    return t;
  endfunction

  // bus responder knobs and state
  int   stall_read = 0, stall_n = 0;
  int   rand_stall = 0, lat = 0, err_read = 0;
  int   rd_cnt = 0, rd_acc = 0, stall_seen = 0;
  bit   acc = 0, in_req = 0;
  txn_t acc_t, s_t;
  int   acc_idx = 0, lat_cnt = 0, stall_left = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      host_gnt_i = 0;
      host_rvalid_i = 0;
      host_err_i = 0;
      host_rdata_i = '0;
      acc = 0;
      in_req = 0;
    end else begin
      host_rvalid_i = 0;
      host_err_i = 0;
      host_rdata_i = '0;
      if (acc) begin
        if (lat_cnt > 0) lat_cnt--;
        else begin
          acc = 0;
          host_rvalid_i = 1;
          if (acc_t.we) begin
            mem[acc_t.addr] = acc_t.data;
            log_q.push_back(acc_t);
          end else begin
            log_q.push_back(mk(1'b0, acc_t.addr,
                               mrd(acc_t.addr)));
            if (acc_idx == err_read) host_err_i = 1;
            else host_rdata_i = mrd(acc_t.addr);
          end
        end
      end
      host_gnt_i = 0;
      if (host_req_o) begin
        if (!in_req) begin
          in_req = 1;
          s_t = mk(host_we_o, host_addr_o, host_wdata_o);
          stall_left = (rand_stall > 0)
            ? int'($urandom_range(rand_stall, 0)) : 0;
          if (!host_we_o) begin
            rd_cnt++;
            if (rd_cnt == stall_read) stall_left = stall_n;
          end
        end else begin
          stall_seen++;
          chk("hold_addr", host_addr_o, s_t.addr);
          chk("hold_we", 32'(host_we_o), 32'(s_t.we));
          if (s_t.we) chk("hold_wdata", host_wdata_o, s_t.data);
        end
        if (stall_left > 0) stall_left--;
        else begin
          host_gnt_i = 1;
          acc = 1;
          acc_t = s_t;
          if (!s_t.we) rd_acc++;
          acc_idx = rd_acc;
          lat_cnt = lat;
          in_req = 0;
        end
      end else if (in_req) begin
        chk("req_dropped", 32'(host_req_o), 32'd1);
        in_req = 0;
      end
    end
  end

  task automatic dev_wr(input logic [31:0] a,
                        input logic [31:0] d,
                        input logic [3:0] be = 4'hF);
    @(negedge clk);
    dev_req_i = 1;
    dev_we_i = 1;
    dev_be_i = be;
    dev_addr_i = a;
    dev_wdata_i = d;
    @(negedge clk);
    dev_req_i = 0;
    dev_we_i = 0;
    dev_be_i = 4'h0;
  endtask

  task automatic dev_rd(input logic [31:0] a,
                        output logic [31:0] d);
    @(negedge clk);
    dev_req_i = 1;
    dev_we_i = 0;
    dev_addr_i = a;
    @(negedge clk);
    chk("dev_rvalid", 32'(dev_rvalid_o), 32'd1);
    d = dev_rdata_o;
    dev_req_i = 0;
  endtask

  task automatic rd_chk(input string tag,
                        input logic [31:0] a,
                        input logic [31:0] exp);
    logic [31:0] v;
    dev_rd(a, v);
    chk(tag, v, exp);
  endtask

  task automatic wait_irq(input int budget);
    int n = 0;
    while (irq_o !== 1'b1 && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk("irq_timeout", 32'(irq_o), 32'd1);
  endtask

  // transfer-level reference: stop_read is the read (1-based) after
  // which nothing more is written (error or abort), 0 for none
  task automatic build_exp(input logic [31:0] src,
                           input logic [31:0] dst,
                           input int len,
                           input int stop_read,
                           input bit fill);
    exp_q.delete();
    for (int i = 0; i < len; i++) begin
      logic [31:0] sa, da;
      sa = src + 32'(4 * i);
      da = dst + 32'(4 * i);
      if (!fill) begin
        exp_q.push_back(mk(1'b0, sa, mrd(sa)));
        if (i + 1 == stop_read) break;
      end
      exp_q.push_back(mk(1'b1, da, fill ? src : mrd(sa)));
    end
  endtask

  task automatic cmp_log(input string tag);
    chk({tag, "_ntxn"}, 32'(log_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < log_q.size(); i++) begin
      chk($sformatf("%s_t%0d_we", tag, i),
          32'(log_q[i].we), 32'(exp_q[i].we));
      chk($sformatf("%s_t%0d_addr", tag, i),
          log_q[i].addr, exp_q[i].addr);
      chk($sformatf("%s_t%0d_data", tag, i),
          log_q[i].data, exp_q[i].data);
    end
  endtask

  task automatic prep(input logic [31:0] src,
                      input logic [31:0] dst,
                      input int len,
                      input int stop_read,
                      input bit fill);
    log_q.delete();
    rd_cnt = 0;
    rd_acc = 0;
    stall_seen = 0;
    for (int i = 0; i < len; i++)
      mem[src + 32'(4 * i)] = $urandom;
    build_exp(src, dst, len, stop_read, fill);
    dev_wr(32'h0, src);
    dev_wr(32'h4, dst);
    dev_wr(32'h8, 32'(len));
  endtask

  task automatic finish(input string tag,
                        input int len_left,
                        input logic [31:0] status);
    wait_irq(4000);
    repeat (2) @(negedge clk);
    cmp_log(tag);
    rd_chk({tag, "_status"}, 32'hC, status);
    rd_chk({tag, "_len"}, 32'h8, 32'(len_left));
    dev_wr(32'hC, 32'h2);
    chk({tag, "_irq_clr"}, 32'(irq_o), 32'd0);
  endtask

  task automatic copy(input string tag,
                      input logic [31:0] src,
                      input logic [31:0] dst,
                      input int len);
    prep(src, dst, len, 0, 0);
    dev_wr(32'hC, 32'h1);
    finish(tag, 0, 32'h2);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (3) @(negedge clk);
    chk("rst_req", 32'(host_req_o), 32'd0);
    chk("rst_irq", 32'(irq_o), 32'd0);
    chk("rst_rvalid", 32'(dev_rvalid_o), 32'd0);
    rst_n = 1;
    rd_chk("rst_src", 32'h0, 32'h0);
    rd_chk("rst_len", 32'h8, 32'h0);
    rd_chk("rst_status", 32'hC, 32'h0);
    chk("dev_err", 32'(dev_err_o), 32'd0);

    // basic 4-word copy, gnt always, rvalid next cycle
    copy("basic", 32'h0010_0000, 32'h0010_0400, 4);

    // LEN=0 start: done without traffic
    log_q.delete();
    dev_wr(32'h8, 32'h0);
    dev_wr(32'hC, 32'h1);
    chk("len0_irq", 32'(irq_o), 32'd1);
    chk("len0_req", 32'(host_req_o), 32'd0);
    rd_chk("len0_status", 32'hC, 32'h2);
    chk("len0_ntxn", 32'(log_q.size()), 32'd0);
    dev_wr(32'hC, 32'h2);
    rd_chk("clr_status", 32'hC, 32'h0);
    dev_wr(32'hC, 32'h3);
    rd_chk("clr_start_status", 32'hC, 32'h2);
    dev_wr(32'hC, 32'h2);

    // partial write ignored, low SRC bits read 0
    dev_wr(32'h0, 32'h1234_5677);
    rd_chk("src_mask", 32'h0, 32'h1234_5674);
    dev_wr(32'h0, 32'hFFFF_FFF0, 4'h3);
    rd_chk("src_partial", 32'h0, 32'h1234_5674);

    // 5-cycle grant stall on second read
    stall_read = 2;
    stall_n = 5;
    copy("stall", 32'h0010_0000, 32'h0010_0400, 6);
    chk("stall_cycles", 32'(stall_seen), 32'd5);
    stall_read = 0;

    // bus error on third read
    err_read = 3;
    prep(32'h0010_0100, 32'h0020_0100, 8, 3, 0);
    dev_wr(32'hC, 32'h1);
    finish("err", 6, 32'h6);
    err_read = 0;

    // abort during RD_WAIT of word 2
    lat = 3;
    prep(32'h0010_0200, 32'h0020_0200, 10, 2, 0);
    dev_wr(32'hC, 32'h1);
    n = 0;
    while (rd_acc < 2 && n < 500) begin
      @(posedge clk);
      n++;
    end
    chk("abort_reach", 32'(rd_acc), 32'd2);
    dev_wr(32'hC, 32'h8);
    finish("abort", 9, 32'h2);
    lat = 0;

    // writes while busy are ignored
    rand_stall = 3;
    prep(32'h0010_0300, 32'h0020_0300, 6, 0, 0);
    dev_wr(32'hC, 32'h1);
    dev_wr(32'h8, 32'd99);
    dev_wr(32'h0, 32'h0030_0000);
    dev_wr(32'hC, 32'h1);
    finish("busy", 0, 32'h2);
    rd_chk("busy_src", 32'h0, 32'h0010_0300);
    rand_stall = 0;

    // randomized copies
    for (int it = 0; it < 6; it++) begin
      logic [31:0] s, d;
      s = 32'h0010_0000 + 32'($urandom_range(255, 0) << 2);
      d = 32'h0020_0000 + 32'($urandom_range(255, 0) << 2);
      rand_stall = int'($urandom_range(3, 0));
      lat = int'($urandom_range(2, 0));
      copy($sformatf("rnd%0d", it), s, d,
           int'($urandom_range(12, 1)));
    end
    rand_stall = 0;
    lat = 0;

`ifdef DMA_FILL_EN
    prep(32'hDEAD_BEEF, 32'h0010_0800, 3, 0, 1);
    dev_wr(32'hC, 32'h5);
    finish("fill", 0, 32'h12);
`endif

    // reset mid-transfer drops req at once
    prep(32'h0010_0000, 32'h0020_0000, 8, 0, 0);
    dev_wr(32'hC, 32'h1);
    n = 0;
    while (host_req_o !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("mid_req_seen", 32'(host_req_o), 32'd1);
    #2 rst_n = 0;
    #1 chk("mid_rst_req", 32'(host_req_o), 32'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    rd_chk("mid_status", 32'hC, 32'h0);
    rd_chk("mid_len", 32'h8, 32'h0);
    chk("mid_irq", 32'(irq_o), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
